// File: rtl/camera_capture_pkg.sv
// Shared types and constants for the camera stream capture front-end.
package camera_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ACTIVE,
    DROP,
    DONE
  } cap_state_t;

  localparam int unsigned ENTRY_DATA_W = 16;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic [ENTRY_DATA_W-1:0] data;
  } fifo_entry_t;

  localparam int unsigned DECIM_SHIFT = 1;

  localparam int unsigned CNT_MAX_W = 32;
  localparam logic [CNT_MAX_W-1:0] CNT_SAT = '1;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rdata while not empty.
module capture_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted when the same cycle pops the head.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/camera_stream_capture.sv
// Crops/decimates a raw sensor stream and emits one Avalon-ST packet per frame.
module camera_stream_capture
  import camera_capture_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned DIM_W      = 12,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] cam_d,
  input  logic              cam_fval,
  input  logic              cam_lval,
  input  logic              cam_pix_en,
  input  logic              enable,
  input  logic [DIM_W-1:0]  cfg_x0,
  input  logic [DIM_W-1:0]  cfg_y0,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic              cfg_decim,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic [CNT_W-1:0]  short_cnt
);

  localparam int unsigned LIM_W  = DIM_W + 1;
  localparam int unsigned SUM_W  = DIM_W + 2;
  localparam int unsigned FIFO_W = DATA_W + 2;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OPEN_W = $clog2(FIFO_DEPTH) + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_SAT);

  cap_state_t state_q, state_d;

  logic              fval_q, lval_q;
  logic [DIM_W-1:0]  x0_q, y0_q, w_q, h_q;
  logic              dec_q;
  logic [LIM_W-1:0]  x_end_q, y_end_q;
  logic [LIM_W-1:0]  x_q, y_q;
  logic              pushed_any_q;
  logic              pend_eop_q;
  logic [OPEN_W-1:0] open_q, open_d;

  logic              fval_rise_c, lval_fall_c, start_ok_c;
  logic [LIM_W-1:0]  dx_c, dy_c, col_c, row_c;
  logic              in_x_c, in_y_c, keep_c, last_c;
  logic              pop_c, can_push_c, eop_pop_c;
  logic              push_c, latch_c, ovf_inc_c, short_inc_c, pend_set_c, pend_clr_c;
  fifo_entry_t       push_entry, rd_entry;

  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  // Exclusive window end in LIM_W bits; clamps instead of wrapping.
  function automatic logic [LIM_W-1:0] win_end(input logic [DIM_W-1:0] org,
                                               input logic [DIM_W-1:0] size,
                                               input logic             dec);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(org) + (SUM_W'(size) << (dec ? DECIM_SHIFT : 0));
    win_end = sum[SUM_W-1] ? '1 : sum[LIM_W-1:0];
  endfunction

  assign fval_rise_c = cam_fval & ~fval_q;
  assign lval_fall_c = ~cam_lval & lval_q;
  assign start_ok_c  = fval_rise_c & enable & (cfg_w != '0) & (cfg_h != '0);

  assign dx_c   = x_q - LIM_W'(x0_q);
  assign dy_c   = y_q - LIM_W'(y0_q);
  assign col_c  = dx_c >> (dec_q ? DECIM_SHIFT : 0);
  assign row_c  = dy_c >> (dec_q ? DECIM_SHIFT : 0);
  assign in_x_c = (x_q >= LIM_W'(x0_q)) && (x_q < x_end_q) && !(dec_q && dx_c[0]);
  assign in_y_c = (y_q >= LIM_W'(y0_q)) && (y_q < y_end_q) && !(dec_q && dy_c[0]);
  assign keep_c = cam_lval & cam_pix_en & in_x_c & in_y_c;
  assign last_c = (col_c == LIM_W'(w_q) - LIM_W'(1)) && (row_c == LIM_W'(h_q) - LIM_W'(1));

  assign pop_c      = st_valid & st_ready;
  assign can_push_c = ~fifo_full | pop_c;
  assign eop_pop_c  = pop_c & st_eop;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    push_c      = 1'b0;
    push_entry  = '0;
    latch_c     = 1'b0;
    ovf_inc_c   = 1'b0;
    short_inc_c = 1'b0;
    pend_set_c  = 1'b0;
    pend_clr_c  = 1'b0;
    unique case (state_q)
      IDLE: if (!cam_fval) state_d = ARM;
      ARM: begin
        if (start_ok_c) begin
          latch_c = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!cam_fval) begin
          // Frame ended early: close the packet with a zero flush beat.
          short_inc_c = 1'b1;
          if (can_push_c) begin
            push_c         = 1'b1;
            push_entry.sop = ~pushed_any_q;
            push_entry.eop = 1'b1;
            state_d        = DONE;
          end else begin
            pend_set_c = 1'b1;
            state_d    = DROP;
          end
        end else if (keep_c) begin
          if (can_push_c) begin
            push_c          = 1'b1;
            push_entry.sop  = ~pushed_any_q;
            push_entry.eop  = last_c;
            push_entry.data = ENTRY_DATA_W'(cam_d);
            if (last_c) state_d = DONE;
          end else begin
            ovf_inc_c  = 1'b1;
            pend_set_c = 1'b1;
            state_d    = DROP;
          end
        end
      end
      DROP: begin
        if (pend_eop_q && can_push_c) begin
          push_c         = 1'b1;
          push_entry.sop = ~pushed_any_q;
          push_entry.eop = 1'b1;
          pend_clr_c     = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: if (!cam_fval) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fval_q <= 1'b0;
      lval_q <= 1'b0;
    end else begin
      fval_q <= cam_fval;
      lval_q <= cam_lval;
    end
  end

  // Window config is frozen for the whole frame at the accepted start edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      dec_q   <= 1'b0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else if (latch_c) begin
      x0_q    <= cfg_x0;
      y0_q    <= cfg_y0;
      w_q     <= cfg_w;
      h_q     <= cfg_h;
      dec_q   <= cfg_decim;
      x_end_q <= win_end(cfg_x0, cfg_w, cfg_decim);
      y_end_q <= win_end(cfg_y0, cfg_h, cfg_decim);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (latch_c) begin
      x_q <= '0;
      y_q <= '0;
    end else if (state_q == ACTIVE) begin
      if (lval_fall_c) begin
        x_q <= '0;
        if (y_q != '1) y_q <= y_q + LIM_W'(1);
      end else if (cam_lval && cam_pix_en && (x_q != '1)) begin
        x_q <= x_q + LIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pushed_any_q <= 1'b0;
      pend_eop_q   <= 1'b0;
    end else begin
      if (latch_c)     pushed_any_q <= 1'b0;
      else if (push_c) pushed_any_q <= 1'b1;
      if (pend_set_c)      pend_eop_q <= 1'b1;
      else if (pend_clr_c) pend_eop_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_cnt <= '0;
      ovf_cnt   <= '0;
      short_cnt <= '0;
    end else begin
      if (eop_pop_c && (frame_cnt != CNT_MAX)) frame_cnt <= frame_cnt + CNT_W'(1);
      if (ovf_inc_c && (ovf_cnt != CNT_MAX))   ovf_cnt   <= ovf_cnt + CNT_W'(1);
      if (short_inc_c && (short_cnt != CNT_MAX)) short_cnt <= short_cnt + CNT_W'(1);
    end
  end

  // Frames still owing an EOP downstream; an older EOP may leave after a new start.
  assign open_d = open_q + OPEN_W'(latch_c) - OPEN_W'(eop_pop_c);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      open_q <= '0;
      busy   <= 1'b0;
    end else begin
      open_q <= open_d;
      busy   <= (open_d != '0);
    end
  end

  assign fifo_wdata = {push_entry.sop, push_entry.eop, DATA_W'(push_entry.data)};

  capture_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (push_c),
    .wdata (fifo_wdata),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rd_entry.sop  = fifo_rdata[DATA_W+1];
  assign rd_entry.eop  = fifo_rdata[DATA_W];
  assign rd_entry.data = ENTRY_DATA_W'(fifo_rdata[DATA_W-1:0]);

  // Head entry is masked while empty so the unreset storage never leaks out.
  assign st_valid = ~fifo_empty;
  assign st_sop   = st_valid & rd_entry.sop;
  assign st_eop   = st_valid & rd_entry.eop;
  assign st_data  = st_valid ? DATA_W'(rd_entry.data) : '0;

  a_fifo_full_level: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
    fifo_full == (fifo_level == LVL_W'(FIFO_DEPTH)));

endmodule
